ud_bcd_counter_n: RTL and testbench

- Parametrised, synchronous, multi-digit up/down BCD counter; successor to the single-digit JK-based up/down BCD counter.
- Adds per-instance digit count, count enable, synchronous parallel load with invalid-digit sanitising, and a terminal-count output for cascading.
- Used as a stand-alone decimal counter or chained via tc into a higher-order instance's en.

---
 rtl/ud_bcd_counter_n.sv | 84 ++++++++
 tb/tb_ud_bcd_counter_n.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ud_bcd_counter_n.sv
// rtl/ud_bcd_counter_n.sv - multi-digit up/down BCD counter with load, sanitising and terminal count
// Optional build macro: UD_BCD_SATURATE_EN (hold at all nines / all zeros instead of wrapping)
module ud_bcd_counter_n #(
  parameter int NDIGITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 x,
  input  logic                 load,
  input  logic [4*NDIGITS-1:0] din,
  output logic [4*NDIGITS-1:0] q,
  output logic                 tc,
  output logic                 load_err
);

  localparam int W = 4 * NDIGITS;
  localparam logic [W-1:0] ALL_NINES = {NDIGITS{4'h9}};

  logic [W-1:0] cnt_next;
  logic [W-1:0] din_clean;
  logic         din_bad;
  logic         all_nines;
  logic         all_zeros;

  assign all_nines = (q == ALL_NINES);
  assign all_zeros = (q == '0);

  // Terminal count: lets a higher-order instance on the same clk count on our wrap
  assign tc = en & (x ? all_zeros : all_nines);

  // Replace any non-decimal load nibble with 0 and flag that it happened
  always_comb begin
    din_clean = din;
    din_bad   = 1'b0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (din[4*k +: 4] > 4'd9) begin
        din_clean[4*k +: 4] = 4'd0;
        din_bad             = 1'b1;
      end
    end
  end

  // One count step: ripple the carry/borrow condition through the digits in a single cycle
  always_comb begin
    logic chain;
    cnt_next = q;
    chain    = 1'b1;
    for (int k = 0; k < NDIGITS; k++) begin
      if (q[4*k +: 4] > 4'd9) begin
        // Out-of-range digit is recovered to 0 rather than stepped
        cnt_next[4*k +: 4] = 4'd0;
      end else if (chain) begin
        if (!x) begin
          cnt_next[4*k +: 4] = (q[4*k +: 4] == 4'd9) ? 4'd0 : q[4*k +: 4] + 4'd1;
        end else begin
          cnt_next[4*k +: 4] = (q[4*k +: 4] == 4'd0) ? 4'd9 : q[4*k +: 4] - 4'd1;
        end
      end
      chain = chain & (x ? (q[4*k +: 4] == 4'd0) : (q[4*k +: 4] == 4'd9));
    end
`ifdef UD_BCD_SATURATE_EN
    if (x ? all_zeros : all_nines) begin
      cnt_next = q;
    end
`endif
  end

  // Count register: load beats count, count beats hold; reset clears asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q        <= '0;
      load_err <= 1'b0;
    end else begin
      load_err <= load & din_bad;
      if (load) begin
        q <= din_clean;
      end else if (en) begin
        q <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_ud_bcd_counter_n.sv
// tb/tb_ud_bcd_counter_n.sv - randomized self-checking bench for ud_bcd_counter_n against a decimal model
module tb_ud_bcd_counter_n;

  localparam int ND  = 2;
  localparam int W   = 4 * ND;
  localparam int MOD = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         x = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] q;
  logic         tc;
  logic         load_err;

  int n_tests = 0;
  int n_fail  = 0;
  int m_val   = 0;
  bit m_err   = 1'b0;

  ud_bcd_counter_n #(.NDIGITS(ND)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .x        (x),
    .load     (load),
    .din      (din),
    .q        (q),
    .tc       (tc),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal model of one rising edge, from the current inputs
  task automatic model_edge();
    int v, p, d;
    bit sat;
    if (!rst) begin
      m_val = 0;
      m_err = 1'b0;
    end else if (load) begin
      v = 0;
      p = 1;
      m_err = 1'b0;
      for (int i = 0; i < ND; i++) begin
        d = int'(din[4*i +: 4]);
        if (d > 9) begin
          d = 0;
          m_err = 1'b1;
        end
        v = v + d * p;
        p = p * 10;
      end
      m_val = v;
    end else begin
      m_err = 1'b0;
      if (en) begin
        sat = 1'b0;
`ifdef UD_BCD_SATURATE_EN
        sat = x ? (m_val == 0) : (m_val == MOD - 1);
`endif
        if (!sat) m_val = x ? (m_val + MOD - 1) % MOD : (m_val + 1) % MOD;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "/q"}, 32'(q), 32'(to_bcd(m_val)));
    check({tag, "/load_err"}, 32'(load_err), 32'(m_err));
    check({tag, "/tc"}, 32'(tc), 32'(en & (x ? (m_val == 0) : (m_val == MOD - 1))));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic drive(input bit l, input bit e, input bit dx, input logic [W-1:0] d);
    load = l;
    en   = e;
    x    = dx;
    din  = d;
  endtask

  initial begin
    // Reset state and tc equation while held in reset
    drive(0, 1, 1, '0);
    #1;
    check("rst/q", 32'(q), 32'h0);
    check("rst/load_err", 32'(load_err), 32'h0);
    check("rst/tc_down", 32'(tc), 32'h1);
    x = 1'b0;
    #1;
    check("rst/tc_up", 32'(tc), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    m_val = 0;
    m_err = 1'b0;

    // Count up twelve steps through the 09->10 carry
    drive(0, 1, 0, '0);
    for (int i = 0; i < 12; i++) tick("up");
    check("up12", 32'(q), 32'h12);

    // Up wrap and tc
    drive(1, 0, 0, 8'h98);
    tick("ld98");
    drive(0, 1, 0, '0);
    #1;
    check_outputs("at98");
    tick("to99");
    check("tc99", 32'(tc), 32'h1);
    tick("wrap_up");
`ifdef UD_BCD_SATURATE_EN
    check("wrap_up_const", 32'(q), 32'h99);
`else
    check("wrap_up_const", 32'(q), 32'h00);
`endif

    // Down count with borrow, then down wrap
    drive(1, 0, 0, 8'h10);
    tick("ld10");
    drive(0, 1, 1, '0);
    tick("dn09");
    check("dn09_const", 32'(q), 32'h09);
    tick("dn08");
    drive(1, 0, 1, 8'h00);
    tick("ld00");
    drive(0, 1, 1, '0);
    #1;
    check_outputs("at00");
    tick("wrap_dn");
`ifdef UD_BCD_SATURATE_EN
    check("wrap_dn_const", 32'(q), 32'h00);
`else
    check("wrap_dn_const", 32'(q), 32'h99);
`endif

    // Direction switch with no turnaround cycle
    drive(1, 0, 0, 8'h00);
    tick("ld00b");
    drive(0, 1, 0, '0);
    for (int i = 0; i < 10; i++) tick("up10");
    check("up10_const", 32'(q), 32'h10);
    x = 1'b1;
    for (int i = 0; i < 3; i++) tick("turn");
    check("turn_const", 32'(q), 32'h07);

    // Load priority and sanitising
    drive(1, 1, 0, 8'h3C);
    tick("ld3c");
    check("ld3c_q", 32'(q), 32'h30);
    check("ld3c_err", 32'(load_err), 32'h1);
    drive(0, 0, 0, '0);
    tick("err_clear");
    check("err_clear_const", 32'(load_err), 32'h0);
    drive(1, 1, 1, 8'h45);
    tick("ld45");
    check("ld45_err", 32'(load_err), 32'h0);

    // Asynchronous reset between edges, then hold with en=0
    drive(1, 0, 0, 8'h57);
    tick("ld57");
    drive(0, 1, 0, '0);
    #2;
    rst = 1'b0;
    #1;
    m_val = 0;
    m_err = 1'b0;
    check("async/q", 32'(q), 32'h0);
    check("async/load_err", 32'(load_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick("hold");
    check("hold_const", 32'(q), 32'h0);

    // Asynchronous reset clears a pending load_err
    drive(1, 0, 0, 8'h7A);
    tick("ld7a");
    load = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    m_val = 0;
    m_err = 1'b0;
    check("async_err/load_err", 32'(load_err), 32'h0);
    check("async_err/q", 32'(q), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the decimal model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        #2;
        rst = 1'b0;
        #1;
        m_val = 0;
        m_err = 1'b0;
        check_outputs("rnd_rst");
        rst = 1'b1;
      end
      load = ($urandom_range(0, 5) == 0);
      en   = ($urandom_range(0, 3) != 0);
      x    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) din = to_bcd(int'($urandom_range(0, MOD - 1)));
      else din = W'($urandom);
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
